// File: rtl/soc_req_arbiter.sv
// Round-robin arbiter: NUM_REQ requesters share one memory-side target, one transaction in flight; optional WAIT watchdog via SOC_ARB_TIMEOUT_EN.
// Latency: accept t -> m_req_valid_o t+1; downstream response k -> rsp_valid_o k+1; decode miss -> error response t+1.
// Backpressure: held request stays stable until m_req_ready_i; req_ready_o is only offered in IDLE, others keep valid.
module soc_req_arbiter #(
    parameter int                    NUM_REQ    = 5,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] MEM_END    = 'h3FFFFFFF,
    parameter logic [ADDR_WIDTH-1:0] DM_BASE    = 'h40000000,
    parameter logic [ADDR_WIDTH-1:0] DM_END     = 'h4007FFFF,
    parameter int                    TIMEOUT    = 1023
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          m_req_valid_o,
    input  logic                          m_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         m_addr_o,
    output logic                          m_we_o,
    output logic [DATA_WIDTH-1:0]         m_wdata_o,
    output logic [$clog2(NUM_REQ)-1:0]    m_id_o,
    input  logic                          m_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]         m_rsp_rdata_i,
    input  logic                          m_rsp_err_i,
    output logic                          busy_o
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       gnt_idx;
    logic                 gnt_found;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                 addr_hit;

`ifdef SOC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     wait_cnt;
`endif

    // Rotating search starting just after the last granted requester.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!gnt_found && req_valid_i[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(j);
            end
        end
    end

    assign gnt_onehot = NUM_REQ'(1) << gnt_idx;
    assign sel_addr   = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata  = req_wdata_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign addr_hit   = (sel_addr <= MEM_END) || ((sel_addr >= DM_BASE) && (sel_addr <= DM_END));

    // Gated by reset so that every output reads zero while reset is held.
    assign req_ready_o = (state == IDLE && gnt_found && !arst_i) ? gnt_onehot : '0;

    // The m_* output registers double as the holding register for the in-flight request.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= IDLE;
            ptr           <= IDW'(NUM_REQ - 1);
            m_req_valid_o <= 1'b0;
            m_addr_o      <= '0;
            m_we_o        <= 1'b0;
            m_wdata_o     <= '0;
            m_id_o        <= '0;
            rsp_valid_o   <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            busy_o        <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        m_addr_o  <= sel_addr;
                        m_we_o    <= req_we_i[gnt_idx];
                        m_wdata_o <= sel_wdata;
                        m_id_o    <= gnt_idx;
                        ptr       <= gnt_idx;
                        busy_o    <= 1'b1;
                        if (addr_hit) begin
                            state         <= ISSUE;
                            m_req_valid_o <= 1'b1;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= gnt_onehot;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_req_ready_i) begin
                        state         <= WAIT;
                        m_req_valid_o <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (m_rsp_valid_i) begin
                        state       <= RESP;
                        rsp_valid_o <= NUM_REQ'(1) << m_id_o;
                        rsp_rdata_o <= m_rsp_rdata_i;
                        rsp_err_o   <= m_rsp_err_i;
`ifdef SOC_ARB_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        rsp_valid_o <= NUM_REQ'(1) << m_id_o;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid_o <= '0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_req_arbiter.sv
// Cycle-by-cycle vector table for arbitration, decode, backpressure and reset, plus a hand sequence for long WAIT / timeout.
module tb_soc_req_arbiter;
    localparam int N  = 5;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk_i = 1'b0;
    logic            arst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_we_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic            m_req_valid_o;
    logic            m_req_ready_i = 1'b0;
    logic [AW-1:0]   m_addr_o;
    logic            m_we_o;
    logic [DW-1:0]   m_wdata_o;
    logic [2:0]      m_id_o;
    logic            m_rsp_valid_i = 1'b0;
    logic [DW-1:0]   m_rsp_rdata_i = '0;
    logic            m_rsp_err_i = 1'b0;
    logic            busy_o;

    soc_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i), .m_addr_o(m_addr_o),
        .m_we_o(m_we_o), .m_wdata_o(m_wdata_o), .m_id_o(m_id_o),
        .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_rdata_i(m_rsp_rdata_i), .m_rsp_err_i(m_rsp_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          rst;
        logic [N-1:0]  vld;
        logic          mrdy;
        logic          mrsp;
        logic [DW-1:0] rdata;
        logic          merr;
        logic [N-1:0]  e_rdy;
        logic          e_mvld;
        logic [2:0]    e_id;
        logic [N-1:0]  e_rsp;
        logic          e_err;
        logic [DW-1:0] e_rdata;
        logic          e_busy;
    } vec_t;

    vec_t          tbl[$];
    logic [AW-1:0] addr_m[N];
    logic [DW-1:0] wdata_m[N];
    logic [N-1:0]  we_m;
    int            checks = 0;
    int            errors = 0;

    function automatic vec_t v(logic rst, logic [N-1:0] vld, logic mrdy, logic mrsp, logic [DW-1:0] rdata,
                               logic merr, logic [N-1:0] e_rdy, logic e_mvld, logic [2:0] e_id,
                               logic [N-1:0] e_rsp, logic e_err, logic [DW-1:0] e_rdata, logic e_busy);
        vec_t r;
        r.rst = rst; r.vld = vld; r.mrdy = mrdy; r.mrsp = mrsp; r.rdata = rdata; r.merr = merr;
        r.e_rdy = e_rdy; r.e_mvld = e_mvld; r.e_id = e_id; r.e_rsp = e_rsp; r.e_err = e_err;
        r.e_rdata = e_rdata; r.e_busy = e_busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int seen;
        addr_m[0] = 'h100;      addr_m[1] = 'h200;      addr_m[2] = 'h1000;
        addr_m[3] = 'h4007FFF8; addr_m[4] = 'h40080000;
        we_m = 5'b00010;
        for (int i = 0; i < N; i++) begin
            wdata_m[i] = 64'hA0 + 64'(i);
            req_addr_i[i*AW +: AW]  = addr_m[i];
            req_wdata_i[i*DW +: DW] = wdata_m[i];
        end
        req_we_i = we_m;

        //                 rst vld      rdy rsp rdata     err  e_rdy    mv id e_rsp    e_err e_rdata   busy
        tbl.push_back(v(1, 5'b11111, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         0)); // 0 reset
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00001, 0, 0, 5'b00000, 0, 0,         0)); // 1 grant 0
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 1, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 1, 'h1111,    0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 0, 0, 5'b00001, 0, 'h1111,    1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00010, 0, 0, 5'b00000, 0, 0,         0)); // 5 grant 1
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 1, 1, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 1, 'h2222,    1,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 0, 0, 5'b00010, 1, 'h2222,    1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00100, 0, 0, 5'b00000, 0, 0,         0)); // 9 grant 2
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 1, 2, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 1, 'hDEAD,    0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 0, 0, 5'b00100, 0, 'hDEAD,    1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b01000, 0, 0, 5'b00000, 0, 0,         0)); // 13 grant 3, DM top
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 1, 3, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 1, 'h3333,    0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 0, 0, 5'b01000, 0, 'h3333,    1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b10000, 0, 0, 5'b00000, 0, 0,         0)); // 17 grant 4, miss
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 0, 0, 5'b10000, 1, 0,         1));
        tbl.push_back(v(0, 5'b11111, 0, 0, 0,         0,   5'b00001, 0, 0, 5'b00000, 0, 0,         0)); // 19 wrap to 0
        for (int k = 0; k < 4; k++)                                                                       // backpressure
            tbl.push_back(v(0, 5'b11111, 0, 0, 0,     0,   5'b00000, 1, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 1, 0, 0,         0,   5'b00000, 1, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b00000, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b00000, 0, 1, 'h4444,    0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b00000, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00001, 0, 'h4444,    1));
        tbl.push_back(v(0, 5'b00000, 0, 1, 'hBAD,     1,   5'b00000, 0, 0, 5'b00000, 0, 0,         0)); // 28 stray rsp in IDLE
        tbl.push_back(v(0, 5'b00000, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         0));
        tbl.push_back(v(0, 5'b00100, 1, 0, 0,         0,   5'b00100, 0, 0, 5'b00000, 0, 0,         0)); // 30 grant 2
        tbl.push_back(v(0, 5'b00000, 1, 0, 0,         0,   5'b00000, 1, 2, 5'b00000, 0, 0,         1));
        tbl.push_back(v(0, 5'b11111, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         1)); // WAIT
        tbl.push_back(v(1, 5'b11111, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         0)); // 33 reset mid-WAIT
        tbl.push_back(v(0, 5'b11111, 0, 1, 'hBEEF,    0,   5'b00001, 0, 0, 5'b00000, 0, 0,         0)); // late rsp ignored
        tbl.push_back(v(0, 5'b00000, 0, 0, 0,         0,   5'b00000, 1, 0, 5'b00000, 0, 0,         1));
        tbl.push_back(v(1, 5'b00000, 0, 0, 0,         0,   5'b00000, 0, 0, 5'b00000, 0, 0,         0));

        next_cycle();
        for (int n = 0; n < tbl.size(); n++) begin
            arst_i        = tbl[n].rst;
            req_valid_i   = tbl[n].vld;
            m_req_ready_i = tbl[n].mrdy;
            m_rsp_valid_i = tbl[n].mrsp;
            m_rsp_rdata_i = tbl[n].rdata;
            m_rsp_err_i   = tbl[n].merr;
            @(negedge clk_i);
            chk($sformatf("r%0d req_ready", n), 64'(req_ready_o), 64'(tbl[n].e_rdy));
            chk($sformatf("r%0d m_req_valid", n), 64'(m_req_valid_o), 64'(tbl[n].e_mvld));
            chk($sformatf("r%0d rsp_valid", n), 64'(rsp_valid_o), 64'(tbl[n].e_rsp));
            chk($sformatf("r%0d busy", n), 64'(busy_o), 64'(tbl[n].e_busy));
            if (tbl[n].e_mvld) begin
                chk($sformatf("r%0d m_id", n), 64'(m_id_o), 64'(tbl[n].e_id));
                chk($sformatf("r%0d m_addr", n), m_addr_o, addr_m[tbl[n].e_id]);
                chk($sformatf("r%0d m_we", n), 64'(m_we_o), 64'(we_m[tbl[n].e_id]));
                chk($sformatf("r%0d m_wdata", n), m_wdata_o, wdata_m[tbl[n].e_id]);
            end
            if (tbl[n].e_rsp != '0) begin
                chk($sformatf("r%0d rsp_err", n), 64'(rsp_err_o), 64'(tbl[n].e_err));
                chk($sformatf("r%0d rsp_rdata", n), rsp_rdata_o, tbl[n].e_rdata);
            end
            if (tbl[n].rst) begin
                chk($sformatf("r%0d rst m_addr", n), m_addr_o, 64'h0);
                chk($sformatf("r%0d rst m_wdata", n), m_wdata_o, 64'h0);
                chk($sformatf("r%0d rst m_id_we", n), {m_id_o, m_we_o}, 64'h0);
                chk($sformatf("r%0d rst rsp", n), {rsp_rdata_o[62:0], rsp_err_o}, 64'h0);
            end
            next_cycle();
        end

        // Long WAIT: watchdog fires when enabled, otherwise the arbiter waits indefinitely.
        arst_i = 1'b0; req_valid_i = 5'b00001; m_req_ready_i = 1'b1; m_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("long accept", 64'(req_ready_o), 64'h1);
        next_cycle();
        req_valid_i = '0;
        @(negedge clk_i);
        chk("long issue", 64'(m_req_valid_o), 64'h1);
        next_cycle();
        m_req_ready_i = 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
        seen = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o != '0 && seen < 0) begin
                seen = c;
                chk("timeout rsp_valid", 64'(rsp_valid_o), 64'h1);
                chk("timeout err", 64'(rsp_err_o), 64'h1);
                chk("timeout rdata", rsp_rdata_o, 64'h0);
            end
            next_cycle();
        end
        chk("timeout cycle", 64'(seen), 64'd8);
        m_rsp_valid_i = 1'b1; m_rsp_rdata_i = 'h77;
        next_cycle();
        m_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("late rsp rsp_valid", 64'(rsp_valid_o), 64'h0);
        chk("late rsp busy", 64'(busy_o), 64'h0);
`else
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk($sformatf("hold c%0d rsp_valid", c), 64'(rsp_valid_o), 64'h0);
            chk($sformatf("hold c%0d busy", c), 64'(busy_o), 64'h1);
            next_cycle();
        end
        m_rsp_valid_i = 1'b1; m_rsp_rdata_i = 'h55; m_rsp_err_i = 1'b0;
        next_cycle();
        m_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("hold rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("hold rsp_rdata", rsp_rdata_o, 64'h55);
        chk("hold rsp_err", 64'(rsp_err_o), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
